window_fetch_buffer: RTL

- Parametrised window fetcher for the block-matching datapath: reads a WIN x WIN pixel window from one shared frame memory port and presents it in parallel to the SAD stage.
- Replaces the fixed 16-parallel-memory approach with a single sequential read port, an address generator, a window register bank and a valid/ready output handshake.
- Sits between frame DataMemory and the SAD/compare logic.

---
 rtl/window_fetch_buffer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/window_fetch_buffer.sv
// rtl/window_fetch_buffer.sv - WIN x WIN window fetcher over one sequential frame-memory read port
//
// Reads a WIN x WIN pixel window, one word per cycle, from a shared frame memory
// and presents it in parallel (row-major) to the SAD stage with a valid/ready handshake.
// Optional feature macro: WINDOW_SLIDE_REUSE_EN - a request one column to the right of
// the last completed window keeps WIN-1 columns and reads only the new right-hand column.
//
// Ports:
//   clk_i, rst_n_i         clock (rising edge), asynchronous active-low reset
//   start_i                fetch request, sampled only while idle
//   base_row_i, base_col_i window top-left corner, sampled with start_i
//   busy_o                 high whenever not idle
//   err_o                  one-cycle pulse for an out-of-frame request
//   mem_rd_o, mem_addr_o   read strobe and address, one word per cycle
//   mem_rddata_i           read data, MEM_LAT cycles after its strobe
//   win_flat_o             window, element k = r*WIN+c at [k*DATA_W +: DATA_W]
//   win_valid_o            window complete and stable
//   win_ready_i            consumer accepts the window
//   done_o                 one-cycle pulse after the valid/ready handshake
module window_fetch_buffer #(
    parameter int DATA_W     = 32,
    parameter int WIN        = 4,
    parameter int FRAME_COLS = 64,
    parameter int FRAME_ROWS = 64,
    parameter int ADDR_W     = 16,
    parameter int MEM_LAT    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_row_i,
    input  logic [ADDR_W-1:0]         base_col_i,
    output logic                      busy_o,
    output logic                      err_o,
    output logic                      mem_rd_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    input  logic [DATA_W-1:0]         mem_rddata_i,
    output logic [WIN*WIN*DATA_W-1:0] win_flat_o,
    output logic                      win_valid_o,
    input  logic                      win_ready_i,
    output logic                      done_o
);
    localparam int N     = WIN * WIN;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);
    localparam int RC_W  = $clog2(WIN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]        row_q, col_q;
    logic [RC_W-1:0]          r_q, c_q;
    logic [CNT_W-1:0]         ret_cnt_q;
    logic                     err_q, done_q;
    logic [N-1:0][DATA_W-1:0] win_q;
    logic                     pipe_vld_q [MEM_LAT];
    logic [IDX_W-1:0]         pipe_idx_q [MEM_LAT];

    logic [ADDR_W:0]  row_end, col_end;
    logic             in_bounds, start_ok, is_slide, slide_q;
    logic             last_issue, ret_fire, ret_last;
    logic [IDX_W-1:0] iss_idx, ret_idx;
    logic [CNT_W-1:0] ret_tgt_m1;

    // One extra bit so a base near the top of the address range cannot wrap past the check.
    assign row_end   = {1'b0, base_row_i} + (ADDR_W+1)'(WIN);
    assign col_end   = {1'b0, base_col_i} + (ADDR_W+1)'(WIN);
    assign in_bounds = (row_end <= (ADDR_W+1)'(FRAME_ROWS)) && (col_end <= (ADDR_W+1)'(FRAME_COLS));
    assign start_ok  = (state_q == S_IDLE) && start_i && in_bounds;

`ifdef WINDOW_SLIDE_REUSE_EN
    logic prev_vld_q;

    // row_q/col_q still hold the base of the last accepted fetch while idle.
    assign is_slide = prev_vld_q && (base_row_i == row_q) && (base_col_i == col_q + ADDR_W'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_vld_q <= 1'b0;
            slide_q    <= 1'b0;
        end else begin
            if (start_ok) begin
                slide_q <= is_slide;
            end
            if ((state_q == S_HOLD) && win_ready_i) begin
                prev_vld_q <= 1'b1;
            end
        end
    end
`else
    assign is_slide = 1'b0;
    assign slide_q  = 1'b0;
`endif

    // A slide walks only column WIN-1, so both modes end on (WIN-1, WIN-1).
    assign last_issue = (state_q == S_FETCH) && (r_q == RC_W'(WIN - 1)) && (c_q == RC_W'(WIN - 1));
    assign iss_idx    = IDX_W'(r_q) * IDX_W'(WIN) + IDX_W'(c_q);
    assign ret_fire   = pipe_vld_q[MEM_LAT-1];
    assign ret_idx    = pipe_idx_q[MEM_LAT-1];
    assign ret_tgt_m1 = slide_q ? CNT_W'(WIN - 1) : CNT_W'(N - 1);
    assign ret_last   = ret_fire && (ret_cnt_q == ret_tgt_m1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_o      = (state_q != S_IDLE);
        mem_rd_o    = 1'b0;
        mem_addr_o  = '0;
        win_valid_o = 1'b0;
        win_flat_o  = win_q;
        err_o       = err_q;
        done_o      = done_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_o   = 1'b1;
                mem_addr_o = (row_q + ADDR_W'(r_q)) * ADDR_W'(FRAME_COLS) + col_q + ADDR_W'(c_q);
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Jump straight on the final return so valid follows it by one cycle.
                if (ret_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                win_valid_o = 1'b1;
                if (win_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            row_q     <= '0;
            col_q     <= '0;
            r_q       <= '0;
            c_q       <= '0;
            ret_cnt_q <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            win_q     <= '0;
            for (int j = 0; j < MEM_LAT; j++) begin
                pipe_vld_q[j] <= 1'b0;
                pipe_idx_q[j] <= '0;
            end
        end else begin
            err_q  <= (state_q == S_IDLE) && start_i && !in_bounds;
            done_q <= (state_q == S_HOLD) && win_ready_i;

            // In-flight tracker: each read carries its destination element to the return side.
            pipe_vld_q[0] <= mem_rd_o;
            pipe_idx_q[0] <= iss_idx;
            for (int j = 1; j < MEM_LAT; j++) begin
                pipe_vld_q[j] <= pipe_vld_q[j-1];
                pipe_idx_q[j] <= pipe_idx_q[j-1];
            end

            if (start_ok) begin
                row_q     <= base_row_i;
                col_q     <= base_col_i;
                r_q       <= '0;
                c_q       <= is_slide ? RC_W'(WIN - 1) : '0;
                ret_cnt_q <= '0;
                if (is_slide) begin
                    for (int rr = 0; rr < WIN; rr++) begin
                        for (int cc = 0; cc < WIN - 1; cc++) begin
                            win_q[rr*WIN+cc] <= win_q[rr*WIN+cc+1];
                        end
                    end
                end
            end

            if (state_q == S_FETCH) begin
                if (c_q == RC_W'(WIN - 1)) begin
                    r_q <= r_q + RC_W'(1);
                    c_q <= slide_q ? RC_W'(WIN - 1) : '0;
                end else begin
                    c_q <= c_q + RC_W'(1);
                end
            end

            if (ret_fire) begin
                win_q[ret_idx] <= mem_rddata_i;
                ret_cnt_q      <= ret_cnt_q + CNT_W'(1);
            end
        end
    end
endmodule
